// File: rtl/fire5_squeeze_buf_if.sv
// Handshake/bus bundle between the fire5 squeeze stage, the squeeze buffer and the expand stage.
// master: squeeze/expand side that drives the buffer; slave: the buffer itself.
interface fire5_squeeze_buf_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 32
);
  logic             sample;
  logic [WIDTH-1:0] din [0:CHANNELS-1];
  logic             layer_finish;
  logic             ram_feedback;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             drain_done;
  logic             replay;

  modport master (
    output sample, din, layer_finish, rd_en, replay,
    input  ram_feedback, dout, dout_valid, drain_done
  );

  modport slave (
    input  sample, din, layer_finish, rd_en, replay,
    output ram_feedback, dout, dout_valid, drain_done
  );
endinterface

// File: rtl/fire5_squeeze_buf.sv
// fire5 squeeze-output feature-map buffer: fills CHANNELS banks of PIXELS words, then drains pixel-major/channel-minor.
// Optional FIRE5_SQUEEZE_BUF_REPLAY_EN: replay in DONE restarts the drain so both expand branches can read the map.
module fire5_squeeze_buf #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 32,
  parameter int unsigned WOUT     = 32
) (
  input logic                clk,
  input logic                rst,
  fire5_squeeze_buf_if.slave bus
);
  localparam int unsigned PIXELS = WOUT * WOUT;
  localparam int unsigned PIX_W  = $clog2(PIXELS);
  localparam int unsigned PTR_W  = PIX_W + 1;
  localparam int unsigned CH_W   = $clog2(CHANNELS);

  typedef enum logic [1:0] {S_FILL, S_ACK, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PIX_W-1:0] r_rd_pix;
  logic [CH_W-1:0]  r_rd_ch;
  logic             r_finish_seen;
  logic             r_ram_feedback;
  logic             r_dout_valid;
  logic             r_drain_done;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_bank_rd [CHANNELS];
  logic             w_full;
  logic             w_last_rd;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_restart;
  logic             w_replay;

  assign w_full    = (r_wr_ptr == PTR_W'(PIXELS));
  assign w_last_rd = (r_rd_pix == PIX_W'(PIXELS - 1)) && (r_rd_ch == CH_W'(CHANNELS - 1));

`ifdef FIRE5_SQUEEZE_BUF_REPLAY_EN
  assign w_replay = bus.replay;
`else
  logic w_unused_replay;
  assign w_unused_replay = bus.replay;
  assign w_replay        = 1'b0;
`endif

  // One bank per channel; every bank is written at wr_ptr on an accepted sample.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_bank
    logic [WIDTH-1:0] r_bank [PIXELS];
    always_ff @(posedge clk) begin
      if (w_wr_en) r_bank[r_wr_ptr[PIX_W-1:0]] <= bus.din[g];
    end
    assign w_bank_rd[g] = r_bank[r_rd_pix];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FILL;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      S_FILL: begin
        w_wr_en = bus.sample && !w_full;
        if (w_full && r_finish_seen) w_state_nxt = S_ACK;
      end
      S_ACK:   w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        w_rd_en = bus.rd_en;
        if (bus.rd_en && w_last_rd) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_replay) begin
          w_restart   = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Pointers, sticky finish flag and registered outputs; wr_ptr saturates at PIXELS to drop trailing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_pix       <= '0;
      r_rd_ch        <= '0;
      r_finish_seen  <= 1'b0;
      r_ram_feedback <= 1'b0;
      r_dout_valid   <= 1'b0;
      r_drain_done   <= 1'b0;
      r_dout         <= '0;
    end else begin
      r_ram_feedback <= (r_state == S_ACK);
      r_dout_valid   <= w_rd_en;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if ((r_state == S_FILL) && bus.layer_finish) r_finish_seen <= 1'b1;
      if (w_rd_en) begin
        r_dout <= w_bank_rd[r_rd_ch];
        if (r_rd_ch == CH_W'(CHANNELS - 1)) begin
          r_rd_ch  <= '0;
          r_rd_pix <= r_rd_pix + PIX_W'(1);
        end else begin
          r_rd_ch <= r_rd_ch + CH_W'(1);
        end
        if (w_last_rd) r_drain_done <= 1'b1;
      end
      if (w_restart) begin
        r_rd_pix     <= '0;
        r_rd_ch      <= '0;
        r_drain_done <= 1'b0;
      end
    end
  end

  assign bus.ram_feedback = r_ram_feedback;
  assign bus.dout         = r_dout;
  assign bus.dout_valid   = r_dout_valid;
  assign bus.drain_done   = r_drain_done;
endmodule

// File: tb/tb_fire5_squeeze_buf.sv
// Scoreboard bench for fire5_squeeze_buf: fill, feedback timing, full/stalled drains, resets and replay.
module tb_fire5_squeeze_buf;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned CHANNELS = 32;
  localparam int unsigned WOUT     = 32;
  localparam int unsigned PIXELS   = WOUT * WOUT;
  localparam int unsigned WORDS    = PIXELS * CHANNELS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fire5_squeeze_buf_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  fire5_squeeze_buf #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .WOUT(WOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int fb_cnt = 0, fb_cyc = 0;
  int valid_cnt = 0, first_valid_cyc = 0, last_valid_cyc = 0;
  int rx_cnt = 0, cyc_w100 = 0, cyc_w101 = 0;
  int acc = 0;
  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] exp_mem [WORDS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge and scored against the queue.
  task automatic tick();
    logic [WIDTH-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ram_feedback) begin
      fb_cnt++;
      fb_cyc = cyc;
    end
    if (bus.dout_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'(bus.dout_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("dout_word", 32'(bus.dout), 32'(e));
        check("drain_done_timing", 32'(bus.drain_done), 32'(sb_q.size() == 0));
      end
      if (valid_cnt == 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
      valid_cnt++;
      if (rx_cnt == 100) cyc_w100 = cyc;
      if (rx_cnt == 101) cyc_w101 = cyc;
      rx_cnt++;
    end
  endtask

  task automatic send_sample(input int p, input logic [WIDTH-1:0] xr, input logic fin);
    logic [WIDTH-1:0] w;
    bus.sample       = 1'b1;
    bus.layer_finish = fin;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      w = WIDTH'(p * int'(CHANNELS) + c) ^ xr;
      bus.din[c] = w;
      if (acc < int'(PIXELS)) begin
        sb_q.push_back(w);
        exp_mem[p * int'(CHANNELS) + c] = w;
      end
    end
    acc++;
    tick();
    bus.sample       = 1'b0;
    bus.layer_finish = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ram_feedback"}, 32'(bus.ram_feedback), 32'd0);
    check({tag, "_dout"},         32'(bus.dout),         32'd0);
    check({tag, "_dout_valid"},   32'(bus.dout_valid),   32'd0);
    check({tag, "_drain_done"},   32'(bus.drain_done),   32'd0);
  endtask

  task automatic run_drain(input string tag);
    int budget;
    budget = 0;
    while (!bus.drain_done && budget < int'(WORDS) + 100) begin
      tick();
      budget++;
    end
    check({tag, "_done_reached"}, 32'(bus.drain_done), 32'd1);
    check({tag, "_word_count"},   32'(valid_cnt), 32'(WORDS));
    check({tag, "_contiguous"},   32'(last_valid_cyc - first_valid_cyc + 1), 32'(WORDS));
    check({tag, "_sb_empty"},     32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin_cyc, last_cyc, k;
    bus.sample = 1'b0; bus.layer_finish = 1'b0; bus.rd_en = 1'b0; bus.replay = 1'b0;
    for (int c = 0; c < int'(CHANNELS); c++) bus.din[c] = '0;

    // Reset state
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b1;

    // Fill without finish, then one trailing sample that must be dropped
    for (int p = 0; p < int'(PIXELS); p++) send_sample(p, 16'h0000, 1'b0);
    repeat (5) tick();
    check("fill_no_feedback", 32'(fb_cnt), 32'd0);
    check("fill_no_valid", 32'(valid_cnt), 32'd0);
    send_sample(int'(PIXELS), 16'hBEEF, 1'b0);
    repeat (3) tick();
    check("no_finish_no_feedback", 32'(fb_cnt), 32'd0);

    bus.layer_finish = 1'b1;
    tick();
    fin_cyc = cyc;
    bus.layer_finish = 1'b0;
    repeat (6) tick();
    check("feedback_count", 32'(fb_cnt), 32'd1);
    check("feedback_latency", 32'(fb_cyc - fin_cyc), 32'd2);
    check("no_valid_before_rd_en", 32'(valid_cnt), 32'd0);

    // Continuous drain
    bus.rd_en = 1'b1;
    run_drain("drain");
    repeat (4) tick();
    check("done_no_valid", 32'(valid_cnt), 32'(WORDS));
    check("done_level", 32'(bus.drain_done), 32'd1);
    check("done_no_feedback", 32'(fb_cnt), 32'd1);

    // Replay from DONE
    valid_cnt = 0;
    rx_cnt    = 0;
`ifdef FIRE5_SQUEEZE_BUF_REPLAY_EN
    for (int i = 0; i < int'(WORDS); i++) sb_q.push_back(exp_mem[i]);
    bus.replay = 1'b1;
    tick();
    bus.replay = 1'b0;
    check("replay_clears_done", 32'(bus.drain_done), 32'd0);
    run_drain("replay");
    check("replay_no_feedback", 32'(fb_cnt), 32'd1);
`else
    bus.replay = 1'b1;
    tick();
    bus.replay = 1'b0;
    repeat (20) tick();
    check("replay_ignored_valid", 32'(valid_cnt), 32'd0);
    check("replay_ignored_done", 32'(bus.drain_done), 32'd1);
`endif

    // Async reset out of DONE
    bus.rd_en = 1'b0;
    rst = 1'b0;
    #1;
    check_zero("reset_done");
    repeat (2) tick();
    rst = 1'b1;
    sb_q.delete();
    acc = 0; fb_cnt = 0; valid_cnt = 0; rx_cnt = 0;

    // Early finish: feedback only once the map is full
    for (int p = 0; p < 10; p++) send_sample(p, 16'h5A5A, 1'b0);
    bus.layer_finish = 1'b1;
    tick();
    bus.layer_finish = 1'b0;
    for (int p = 10; p < int'(PIXELS) - 1; p++) send_sample(p, 16'h5A5A, 1'b0);
    repeat (4) tick();
    check("early_finish_no_feedback", 32'(fb_cnt), 32'd0);
    send_sample(int'(PIXELS) - 1, 16'h5A5A, 1'b0);
    last_cyc = cyc;
    repeat (5) tick();
    check("early_finish_feedback", 32'(fb_cnt), 32'd1);
    check("early_finish_latency", 32'(fb_cyc - last_cyc), 32'd2);

    // Drain with a two-cycle stall after word 100, reset at word 5000
    k = 0;
    while (rx_cnt < 5000 && k < 6000) begin
      bus.rd_en = !(k == 101 || k == 102);
      tick();
      if (k == 101 || k == 102) check("stall_hold_dout", 32'(bus.dout), 32'(exp_mem[100]));
      k++;
    end
    check("stall_gap", 32'(cyc_w101 - cyc_w100), 32'd3);
    check("stall_rx_count", 32'(rx_cnt), 32'd5000);
    rst = 1'b0;
    #1;
    check_zero("reset_mid_drain");
    bus.rd_en = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    sb_q.delete();
    acc = 0; fb_cnt = 0; valid_cnt = 0; rx_cnt = 0;

    // After reset: empty map, finish flag cleared, fresh data read back
    for (int p = 0; p < int'(PIXELS); p++) send_sample(p, 16'h0F0F, 1'b0);
    repeat (5) tick();
    check("post_reset_no_feedback", 32'(fb_cnt), 32'd0);
    bus.layer_finish = 1'b1;
    tick();
    bus.layer_finish = 1'b0;
    repeat (5) tick();
    check("post_reset_feedback", 32'(fb_cnt), 32'd1);
    bus.rd_en = 1'b1;
    repeat (40) tick();
    bus.rd_en = 1'b0;
    check("post_reset_words", 32'(valid_cnt), 32'd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
